// File: rtl/fc_pkg.sv
// fc_pkg: shared types and helpers for the sequential fully-connected
// classifier (fc_seq_argmax) and its argmax datapath (argmax_seq).
//   state_t  - controller states
//   clog2w   - index/address width helper, never narrower than 1 bit
//   sat_add  - signed add clamped to a w-bit two's complement range
package fc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_CMP,
    S_DONE
  } state_t;

  // Width needed to index n items; a 1-entry range still needs one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands arrive already sign-extended to 64 bits, so the raw sum cannot
  // overflow for any practical accumulator width; only the clamp matters.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/argmax_seq.sv
// argmax_seq: sequential signed argmax over N_OUT accumulator values.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle strobe; vals must be final from this cycle on
//   vals        - packed values, class c at [c*ACC_W +: ACC_W]
//   done        - high in the cycle that examines the last class
//   idx         - winning index (valid after the done cycle)
//   none        - tie for the maximum seen and TIE_LOWEST=0
// One class is examined per cycle: c=1 in the start cycle, then 2..N_OUT-1.
// Requires N_OUT >= 2.
module argmax_seq import fc_pkg::*; #(
  parameter  int N_OUT      = 10,
  parameter  int ACC_W      = 10,
  parameter  int TIE_LOWEST = 1,
  localparam int IDX_W      = clog2w(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_OUT*ACC_W-1:0]   vals,
  output logic                     done,
  output logic [IDX_W-1:0]         idx,
  output logic                     none
);

  logic                    busy_reg;
  logic [IDX_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    tie_reg;
  logic signed [ACC_W-1:0] best_reg;

  logic                    active;
  logic [IDX_W-1:0]        cur_c;
  logic [IDX_W-1:0]        cur_idx;
  logic                    cur_tie;
  logic signed [ACC_W-1:0] cur_best;
  logic signed [ACC_W-1:0] cand;
  logic signed [ACC_W-1:0] best_next;
  logic [IDX_W-1:0]        idx_next;
  logic                    tie_next;

  always_comb begin
    active   = start | busy_reg;
    // In the start cycle the running best is seeded from class 0 directly,
    // saving a separate load cycle.
    cur_c    = start ? IDX_W'(1) : cnt_reg;
    cur_best = start ? $signed(vals[ACC_W-1:0]) : best_reg;
    cur_idx  = start ? '0 : idx_reg;
    cur_tie  = start ? 1'b0 : tie_reg;
    cand     = $signed(vals[cur_c*ACC_W +: ACC_W]);

    best_next = cur_best;
    idx_next  = cur_idx;
    tie_next  = cur_tie;
    if (cand > cur_best) begin
      best_next = cand;
      idx_next  = cur_c;
      tie_next  = 1'b0;
    end else if (cand == cur_best) begin
      tie_next = 1'b1;
    end

    done = active && (cur_c == IDX_W'(N_OUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
      idx_reg  <= '0;
      tie_reg  <= 1'b0;
      best_reg <= '0;
    end else if (active) begin
      best_reg <= best_next;
      idx_reg  <= idx_next;
      tie_reg  <= tie_next;
      if (done) begin
        busy_reg <= 1'b0;
      end else begin
        busy_reg <= 1'b1;
        cnt_reg  <= cur_c + IDX_W'(1);
      end
    end
  end

  assign idx  = idx_reg;
  assign none = (TIE_LOWEST == 0) ? tie_reg : 1'b0;

endmodule

// File: rtl/fc_seq_argmax.sv
// fc_seq_argmax: time-multiplexed final fully-connected layer + argmax.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - activation vector handshake; in_data element i at
//                          [i*IN_W +: IN_W], signed
//   cfg_we/addr/data     - weight/bias write; addr = class*(N_IN+1)+j,
//                          j=N_IN selects the bias; accepted only in IDLE
//   out_valid/out_ready  - result handshake
//   out_onehot, out_idx  - winner (zero when there is no winner)
//   out_none             - no unique winner (TIE_LOWEST=0 only)
//   cfg_err              - sticky, a write arrived while busy
module fc_seq_argmax import fc_pkg::*; #(
  parameter  int N_IN       = 32,
  parameter  int N_OUT      = 10,
  parameter  int IN_W       = 4,
  parameter  int WT_W       = 4,
  parameter  int ACC_W      = 10,
  parameter  int TIE_LOWEST = 1,
  localparam int ADDR_W     = clog2w(N_OUT * (N_IN + 1)),
  localparam int IDX_W      = clog2w(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [ACC_W-1:0]       cfg_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT-1:0]       out_onehot,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_none,
  output logic                   cfg_err
);

  localparam int CNT_W = clog2w(N_IN);
  localparam int P_W   = IN_W + WT_W;
  localparam int ROW   = N_IN + 1;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]        cnt_reg;
  logic                    cmp_start_reg;
  logic                    cfg_err_reg;
  logic signed [IN_W-1:0]  in_reg   [N_IN];
  logic signed [WT_W-1:0]  w_reg    [N_OUT][N_IN];
  logic signed [ACC_W-1:0] bias_reg [N_OUT];
  logic signed [ACC_W-1:0] acc_reg  [N_OUT];

  logic                     accept;
  logic                     cfg_wr;
  logic                     last_in;
  logic signed [IN_W-1:0]   cur_in;
  logic [N_OUT*ACC_W-1:0]   acc_flat;
  logic [N_OUT*ACC_W-1:0]   acc_next_flat;
  logic                     cmp_done;
  logic [IDX_W-1:0]         res_idx;
  logic                     res_none;

  assign accept  = in_valid && (state_reg == S_IDLE);
  assign cfg_wr  = cfg_we && (state_reg == S_IDLE);
  assign last_in = (cnt_reg == CNT_W'(N_IN - 1));
  assign cur_in  = in_reg[cnt_reg];

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_ACC;
      end
      S_ACC:  if (last_in) state_next = S_CMP;
      S_CMP:  if (cmp_done) state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      cmp_start_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      // Fires in the first CMP cycle, once the final input has been summed.
      cmp_start_reg <= (state_reg == S_ACC) && last_in;
      if (accept)
        cnt_reg <= '0;
      else if ((state_reg == S_ACC) && !last_in)
        cnt_reg <= cnt_reg + CNT_W'(1);
      if (cfg_we && (state_reg != S_IDLE))
        cfg_err_reg <= 1'b1;
    end
  end

  assign cfg_err = cfg_err_reg;

  // ---------------- input latch ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++)
        in_reg[i] <= $signed(in_data[i*IN_W +: IN_W]);
    end
  end

  // ---------------- weight / bias store ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_OUT; c++) begin
        bias_reg[c] <= '0;
        for (int j = 0; j < N_IN; j++) w_reg[c][j] <= '0;
      end
    end else if (cfg_wr) begin
      for (int c = 0; c < N_OUT; c++) begin
        for (int j = 0; j < N_IN; j++)
          if (cfg_addr == ADDR_W'(c * ROW + j))
            w_reg[c][j] <= $signed(cfg_data[WT_W-1:0]);
        if (cfg_addr == ADDR_W'(c * ROW + N_IN))
          bias_reg[c] <= $signed(cfg_data);
      end
    end
  end

  // ---------------- per-class MAC ----------------
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_mac
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] sum;
    assign prod = P_W'(cur_in) * P_W'(w_reg[gi][cnt_reg]);
    assign sum  = ACC_W'(sat_add(64'(acc_reg[gi]), 64'(prod), ACC_W));
    assign acc_next_flat[gi*ACC_W +: ACC_W] = sum;
    assign acc_flat[gi*ACC_W +: ACC_W]      = acc_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_OUT; c++) acc_reg[c] <= '0;
    end else if (accept) begin
      // A bias written in the accept cycle is forwarded so the new vector
      // sees it, matching the weights which are only read from next cycle.
      for (int c = 0; c < N_OUT; c++)
        acc_reg[c] <= (cfg_wr && (cfg_addr == ADDR_W'(c * ROW + N_IN)))
                      ? $signed(cfg_data) : bias_reg[c];
    end else if (state_reg == S_ACC) begin
      for (int c = 0; c < N_OUT; c++)
        acc_reg[c] <= $signed(acc_next_flat[c*ACC_W +: ACC_W]);
    end
  end

  // ---------------- argmax ----------------
  argmax_seq #(
    .N_OUT     (N_OUT),
    .ACC_W     (ACC_W),
    .TIE_LOWEST(TIE_LOWEST)
  ) u_argmax (
    .clk  (clk),
    .rst_n(rst_n),
    .start(cmp_start_reg),
    .vals (acc_flat),
    .done (cmp_done),
    .idx  (res_idx),
    .none (res_none)
  );

  // Result registers live in argmax_seq and only move during CMP, so these
  // are stable for the whole DONE state; gating keeps them zero elsewhere.
  assign out_none   = out_valid && res_none;
  assign out_idx    = (out_valid && !res_none) ? res_idx : '0;
  assign out_onehot = (out_valid && !res_none) ? (N_OUT'(1) << res_idx) : '0;

endmodule

// File: tb/tb_fc_seq_argmax.sv
// Testbench for fc_seq_argmax: two instances (lowest-index tie policy and
// strict tie policy) share all stimulus; a behavioural model predicts the
// winner of each vector and a compare process checks every valid cycle.
module tb_fc_seq_argmax;
  localparam int N_IN   = 32;
  localparam int N_OUT  = 10;
  localparam int IN_W   = 4;
  localparam int WT_W   = 4;
  localparam int ACC_W  = 10;
  localparam int ADDR_W = 9;
  localparam int IDX_W  = 4;
  localparam int ROW    = N_IN + 1;
  localparam int LAT    = N_IN + N_OUT - 1;
  localparam int SAT_HI = (1 << (ACC_W - 1)) - 1;
  localparam int SAT_LO = -(1 << (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [N_IN*IN_W-1:0] in_data = '0;
  logic cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [ACC_W-1:0] cfg_data = '0;
  logic out_ready = 1'b0;

  logic ir_a, ov_a, on_a, ce_a, ir_b, ov_b, on_b, ce_b;
  logic [N_OUT-1:0] oh_a, oh_b;
  logic [IDX_W-1:0] oi_a, oi_b;

  always #5 clk = ~clk;

  fc_seq_argmax #(.TIE_LOWEST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_onehot(oh_a), .out_idx(oi_a),
    .out_none(on_a), .cfg_err(ce_a));

  fc_seq_argmax #(.TIE_LOWEST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_onehot(oh_b), .out_idx(oi_b),
    .out_none(on_b), .cfg_err(ce_b));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int mw [N_OUT][N_IN];
  int mb [N_OUT];
  int vec [N_IN];
  int ea_idx = 0;
  bit eb_none = 1'b0;

  function automatic void model_clear();
    for (int c = 0; c < N_OUT; c++) begin
      mb[c] = 0;
      for (int j = 0; j < N_IN; j++) mw[c][j] = 0;
    end
  endfunction

  function automatic void model_write(input int addr, input int data);
    logic signed [WT_W-1:0]  t_w;
    logic signed [ACC_W-1:0] t_b;
    int c, j;
    c = addr / ROW;
    j = addr % ROW;
    t_w = data[WT_W-1:0];
    t_b = data[ACC_W-1:0];
    if (j == N_IN) mb[c] = int'(t_b);
    else           mw[c][j] = int'(t_w);
  endfunction

  // Winner = lowest index holding the maximum; tie = maximum held twice+.
  function automatic void predict(output int idx, output bit none);
    int acc [N_OUT];
    int mx, nmax;
    for (int c = 0; c < N_OUT; c++) begin
      acc[c] = mb[c];
      for (int i = 0; i < N_IN; i++) begin
        acc[c] = acc[c] + vec[i] * mw[c][i];
        if (acc[c] > SAT_HI) acc[c] = SAT_HI;
        if (acc[c] < SAT_LO) acc[c] = SAT_LO;
      end
    end
    mx = acc[0];
    for (int c = 1; c < N_OUT; c++) if (acc[c] > mx) mx = acc[c];
    idx = 0;
    nmax = 0;
    for (int c = N_OUT - 1; c >= 0; c--)
      if (acc[c] == mx) begin
        nmax++;
        idx = c;
      end
    none = (nmax > 1);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov_a) begin
        chk("a_idx", int'(oi_a), ea_idx);
        chk("a_onehot", int'(oh_a), 1 << ea_idx);
        chk("a_none", int'(on_a), 0);
      end
      if (ov_b) begin
        chk("b_idx", int'(oi_b), eb_none ? 0 : ea_idx);
        chk("b_onehot", int'(oh_b), eb_none ? 0 : (1 << ea_idx));
        chk("b_none", int'(on_b), int'(eb_none));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr[ADDR_W-1:0];
    cfg_data = data[ACC_W-1:0];
    @(posedge clk);
    #1 cfg_we = 1'b0;
    model_write(addr, data);
  endtask

  task automatic set_vec(input int v);
    for (int i = 0; i < N_IN; i++) vec[i] = v;
  endtask

  task automatic drive_vec();
    for (int i = 0; i < N_IN; i++) in_data[i*IN_W +: IN_W] = vec[i][IN_W-1:0];
  endtask

  // Sends vec, checks latency, optionally stalls (with a stray cfg write),
  // then completes the output handshake. Returns the captured results.
  task automatic run_vec(input int stall, input bit stray, input int sim_addr,
                         input int sim_data, input string tag,
                         output int got_a, output int got_oh_a,
                         output int got_b, output int got_none_b);
    int cycles;
    bit seen;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, int'(ir_a), 1);
    drive_vec();
    in_valid = 1'b1;
    if (sim_addr >= 0) begin
      cfg_we   = 1'b1;
      cfg_addr = sim_addr[ADDR_W-1:0];
      cfg_data = sim_data[ACC_W-1:0];
      model_write(sim_addr, sim_data);
    end
    predict(ea_idx, eb_none);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1;
      if (ov_a && ov_b) seen = 1'b1;
    end
    chk({tag, "_latency"}, cycles, LAT);
    got_a = int'(oi_a);
    got_oh_a = int'(oh_a);
    got_b = int'(oi_b);
    got_none_b = int'(on_b);
    for (int s = 0; s < stall; s++) begin
      if (stray && s == 3) begin
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(9 * ROW + N_IN);
        cfg_data = ACC_W'(100);
      end
      @(posedge clk);
      #1 cfg_we = 1'b0;
      chk({tag, "_stall_in_ready"}, int'(ir_a), 0);
      chk({tag, "_stall_valid"}, int'(ov_a), 1);
    end
    if (stray) begin
      chk({tag, "_cfg_err_a"}, int'(ce_a), 1);
      chk({tag, "_cfg_err_b"}, int'(ce_b), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(ov_a), 0);
    chk({tag, "_in_ready_back"}, int'(ir_a), 1);
    $display("txn %s: idx_a=%0d onehot_a=0x%03h idx_b=%0d none_b=%0d lat=%0d",
             tag, got_a, got_oh_a, got_b, got_none_b, cycles);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ga, goh, gb, gnb;

    // Reset state
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low_rst", int'(ir_a), 1);
    chk("rst_out_valid_low_rst", int'(ov_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(ir_a), 1);
    chk("rst_out_valid", int'(ov_a) | int'(ov_b), 0);
    chk("rst_onehot", int'(oh_a), 0);
    chk("rst_idx", int'(oi_a), 0);
    chk("rst_none", int'(on_b), 0);
    chk("rst_cfg_err", int'(ce_a) | int'(ce_b), 0);

    // T1: bias[3]=5, zero weights
    cfg_write(3 * ROW + N_IN, 5);
    for (int i = 0; i < N_IN; i++) vec[i] = (i % 16) - 8;
    run_vec(0, 1'b0, -1, 0, "bias3", ga, goh, gb, gnb);
    chk("t1_idx", ga, 3);
    chk("t1_onehot", goh, 8);
    chk("t1_b_idx", gb, 3);
    chk("t1_b_none", gnb, 0);

    // T2: w[7][*]=1
    do_reset();
    for (int i = 0; i < N_IN; i++) cfg_write(7 * ROW + i, 1);
    set_vec(7);
    run_vec(0, 1'b0, -1, 0, "w7_pos", ga, goh, gb, gnb);
    chk("t2_idx", ga, 7);
    set_vec(-8);
    run_vec(0, 1'b0, -1, 0, "w7_neg", ga, goh, gb, gnb);
    chk("t2n_idx", ga, 0);
    chk("t2n_b_none", gnb, 1);
    chk("t2n_b_idx", gb, 0);

    // T3: saturation both ways, with backpressure and a stray cfg write
    do_reset();
    for (int i = 0; i < N_IN; i++) begin
      cfg_write(2 * ROW + i, 7);
      cfg_write(5 * ROW + i, -8);
    end
    set_vec(7);
    run_vec(20, 1'b1, -1, 0, "sat_stall", ga, goh, gb, gnb);
    chk("t3_idx", ga, 2);
    chk("t3_model_idx", ea_idx, 2);
    // Stray bias[9]=100 must not have landed: zero inputs leave all-zero sums.
    set_vec(0);
    run_vec(0, 1'b0, -1, 0, "after_stray", ga, goh, gb, gnb);
    chk("t3z_idx", ga, 0);
    chk("t3z_b_none", gnb, 1);

    // T4: tie between classes 4 and 6
    do_reset();
    chk("t4_cfg_err_cleared", int'(ce_a), 0);
    cfg_write(4 * ROW + N_IN, 9);
    cfg_write(6 * ROW + N_IN, 9);
    for (int i = 0; i < N_IN; i++) vec[i] = (i * 3) % 16 - 8;
    run_vec(0, 1'b0, -1, 0, "tie", ga, goh, gb, gnb);
    chk("t4_idx", ga, 4);
    chk("t4_b_none", gnb, 1);
    chk("t4_model_none", int'(eb_none), 1);

    // T5: cfg write in the accept cycle is used by that vector
    run_vec(0, 1'b0, 8 * ROW + N_IN, 50, "cfg_at_accept", ga, goh, gb, gnb);
    chk("t5_idx", ga, 8);
    chk("t5_b_idx", gb, 8);
    chk("t5_b_none", gnb, 0);

    // T6: reset in the middle of accumulation
    set_vec(7);
    @(negedge clk);
    drive_vec();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_in_rst", int'(ov_a) | int'(ov_b), 0);
    chk("t6_in_ready_in_rst", int'(ir_a) & int'(ir_b), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    chk("t6_valid_after", int'(ov_a), 0);
    run_vec(0, 1'b0, -1, 0, "after_reset", ga, goh, gb, gnb);
    chk("t6_idx", ga, 0);
    chk("t6_b_none", gnb, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
